sram_pattern_tester: RTL and testbench

//  Initiator on the sram controller's user-side handshake (address/data_write/write/read/ready/data_read).

---
 rtl/sram_pattern_tester.sv | 204 ++++++++++++++++++++
 tb/tb_sram_pattern_tester.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_pattern_tester.sv
// Memory self-test initiator for the sram controller user handshake: writes an address-seeded
// pattern over 0..LAST_ADDR, reads it back, then repeats with the complement, counting mismatches.
module sram_pattern_tester #(
  parameter int unsigned       ADDR_W    = 18,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       LAST_ADDR = 2**18-1,
  parameter logic [DATA_W-1:0] PATTERN   = 16'hA5C3,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_read,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_write,
  output logic              write,
  output logic              read,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam int unsigned       TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);

  typedef enum logic [3:0] {
    IDLE, W_ISSUE, W_WAIT_LO, W_WAIT_HI,
    R_ISSUE, R_WAIT_LO, R_WAIT_HI, R_CHECK,
    DONE, TIMEOUT_ERR
  } state_t;

  state_t            state, state_nx;
  logic              phase, phase_nx;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
  logic [ADDR_W-1:0] address_nx, fail_addr_nx;
  logic [DATA_W-1:0] data_write_nx, fail_data_nx, rd_capt;
  logic              write_nx, read_nx, busy_nx, done_nx, pass_nx, timeout_nx;
  logic [15:0]       err_nx;
  logic              stall;

  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a, input logic ph);
    logic [DATA_W-1:0] w;
    w = DATA_W'(a) ^ PATTERN;
    return ph ? ~w : w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nx      = state;
    phase_nx      = phase;
    tmo_nx        = '0;
    address_nx    = address;
    data_write_nx = data_write;
    write_nx      = 1'b0;
    read_nx       = 1'b0;
    busy_nx       = busy;
    done_nx       = done;
    pass_nx       = pass;
    timeout_nx    = timeout;
    err_nx        = error_count;
    fail_addr_nx  = fail_addr;
    fail_data_nx  = fail_data;
    stall         = 1'b0;

    case (state)
      IDLE, DONE, TIMEOUT_ERR: begin
        if (start) begin
          state_nx     = W_ISSUE;
          phase_nx     = 1'b0;
          address_nx   = '0;
          busy_nx      = 1'b1;
          done_nx      = 1'b0;
          pass_nx      = 1'b0;
          timeout_nx   = 1'b0;
          err_nx       = '0;
          fail_addr_nx = '0;
          fail_data_nx = '0;
        end
      end
      W_ISSUE: begin
        if (ready) begin
          data_write_nx = exp_word(address, phase);
          write_nx      = 1'b1;
          state_nx      = W_WAIT_LO;
        end
      end
      W_WAIT_LO: begin
        if (!ready) state_nx = W_WAIT_HI;
        else        stall    = 1'b1;
      end
      W_WAIT_HI: begin
        if (!ready) begin
          stall = 1'b1;
        end else if (address == LAST) begin
          address_nx = '0;
          state_nx   = R_ISSUE;
        end else begin
          address_nx = address + ADDR_W'(1);
          state_nx   = W_ISSUE;
        end
      end
      R_ISSUE: begin
        if (ready) begin
          read_nx  = 1'b1;
          state_nx = R_WAIT_LO;
        end
      end
      R_WAIT_LO: begin
        if (!ready) state_nx = R_WAIT_HI;
        else        stall    = 1'b1;
      end
      R_WAIT_HI: begin
        if (ready) state_nx = R_CHECK;
        else       stall    = 1'b1;
      end
      R_CHECK: begin
        if (rd_capt != exp_word(address, phase)) begin
          err_nx = sat_inc(error_count);
          // error_count of zero marks the first mismatch of the run
          if (error_count == 16'd0) begin
            fail_addr_nx = address;
            fail_data_nx = rd_capt;
          end
        end
        if (address != LAST) begin
          address_nx = address + ADDR_W'(1);
          state_nx   = R_ISSUE;
        end else if (!phase) begin
          phase_nx   = 1'b1;
          address_nx = '0;
          state_nx   = W_ISSUE;
        end else begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (err_nx == 16'd0);
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Leaving a wait state resets tmo_nx to zero via its default
    if (stall) begin
      if (tmo_cnt == TMO_LAST) begin
        state_nx   = TIMEOUT_ERR;
        busy_nx    = 1'b0;
        done_nx    = 1'b1;
        timeout_nx = 1'b1;
        pass_nx    = 1'b0;
      end else begin
        tmo_nx = tmo_cnt + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= 1'b0;
      tmo_cnt     <= '0;
      address     <= '0;
      data_write  <= '0;
      write       <= 1'b0;
      read        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      error_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state       <= state_nx;
      phase       <= phase_nx;
      tmo_cnt     <= tmo_nx;
      address     <= address_nx;
      data_write  <= data_write_nx;
      write       <= write_nx;
      read        <= read_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      pass        <= pass_nx;
      timeout     <= timeout_nx;
      error_count <= err_nx;
      fail_addr   <= fail_addr_nx;
      fail_data   <= fail_data_nx;
    end
  end

  // Read data is sampled on the edge where ready returns high after a read
  always_ff @(posedge clk) begin
    if (state == R_WAIT_HI && ready) rd_capt <= data_read;
  end

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Directed bench for sram_pattern_tester against a small latency-configurable sram controller model.
module tb_sram_pattern_tester;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int LAST   = 7;
  localparam int TMO    = 16;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              ready;
  logic [DATA_W-1:0] data_read;
  logic [ADDR_W-1:0] address, fail_addr;
  logic [DATA_W-1:0] data_write, fail_data;
  logic              write, read, busy, done, pass, timeout;
  logic [15:0]       error_count;

  int vectors = 0;
  int miscompares = 0;
  int fault_mode = 0;
  logic hold = 1'b0;
  int writes = 0, reads = 0, viol = 0;
  int w0, r0, n;

  always #5 clk = ~clk;

  sram_pattern_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST),
    .PATTERN(16'hA5C3), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .data_read(data_read),
    .address(address), .data_write(data_write), .write(write), .read(read),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  // Controller model: accepts one request while ready, holds ready low LAT cycles, then completes.
  // fault_mode 1: bit 3 stuck at 0 on reads of address 5; fault_mode 2: bit 3 inverted there.
  logic [DATA_W-1:0] mem [0:7];
  int                cnt;
  logic              op_wr, wr_q, rd_q;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;

  function automatic logic [DATA_W-1:0] fault(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = d;
    if (a == ADDR_W'(5)) begin
      if (fault_mode == 1)      r[3] = 1'b0;
      else if (fault_mode == 2) r[3] = ~r[3];
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready     <= 1'b1;
      cnt       <= 0;
      data_read <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      wr_q <= write;
      rd_q <= read;
      if (write) writes <= writes + 1;
      if (read)  reads  <= reads + 1;
      if ((write && read) || ((write || read) && !ready) || (write && wr_q) || (read && rd_q))
        viol <= viol + 1;
      if (ready) begin
        if ((write || read) && !hold) begin
          ready   <= 1'b0;
          cnt     <= LAT;
          op_wr   <= write;
          op_addr <= address;
          op_data <= data_write;
        end
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else begin
        ready <= 1'b1;
        if (op_wr) mem[op_addr[2:0]] <= op_data;
        else       data_read <= fault(mem[op_addr[2:0]], op_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_write", write, 0);
    chk("rst_read", read, 0);
    chk("rst_err", error_count, 0);
    chk("rst_addr", address, 0);
    reset = 1'b1;

    // 1: ideal memory, 8 words, both passes
    w0 = writes; r0 = reads;
    pulse_start();
    wait_done("t1_done");
    chk("t1_pass", pass, 1);
    chk("t1_err", error_count, 0);
    chk("t1_tmo", timeout, 0);
    chk("t1_busy", busy, 0);
    chk("t1_writes", writes - w0, 16);
    chk("t1_reads", reads - r0, 16);

    // 2a: bit 3 stuck low at addr 5 only shows in the complement pass (A5C6 already has bit 3 = 0)
    fault_mode = 1;
    pulse_start();
    wait_done("t2a_done");
    chk("t2a_err", error_count, 1);
    chk("t2a_faddr", fail_addr, 5);
    chk("t2a_fdata", fail_data, 16'h5A31);
    chk("t2a_pass", pass, 0);

    // 2b + 5: bit 3 flipped at addr 5 fails both passes; start while busy is ignored
    fault_mode = 2;
    w0 = writes; r0 = reads;
    pulse_start();
    chk("t5_done_clr", done, 0);
    chk("t5_pass_clr", pass, 0);
    chk("t5_busy", busy, 1);
    chk("t5_err_clr", error_count, 0);
    n = 0;
    while (error_count != 16'd1 && n < 2000) begin @(negedge clk); n++; end
    chk("t5_err_seen", error_count, 1);
    pulse_start();
    chk("t5_ign_err", error_count, 1);
    chk("t5_ign_busy", busy, 1);
    wait_done("t2b_done");
    chk("t2b_err", error_count, 2);
    chk("t2b_faddr", fail_addr, 5);
    chk("t2b_fdata", fail_data, 16'hA5CE);
    chk("t2b_pass", pass, 0);
    chk("t5_writes", writes - w0, 16);
    chk("t5_reads", reads - r0, 16);

    // 3: controller never drops ready -> timeout TMO cycles after the write pulse
    fault_mode = 0;
    hold = 1'b1;
    w0 = writes; r0 = reads;
    pulse_start();
    n = 0;
    while (!write && n < 100) begin @(negedge clk); n++; end
    chk("t3_wpulse", write, 1);
    n = 0;
    while (!timeout && n < 100) begin @(negedge clk); n++; end
    chk("t3_cycles", n, TMO);
    chk("t3_tmo", timeout, 1);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("t3_writes", writes - w0, 1);
    chk("t3_reads", reads - r0, 0);

    // 4: asynchronous reset during a write pulse, then a clean rerun
    hold = 1'b0;
    pulse_start();
    chk("t4_tmo_clr", timeout, 0);
    n = 0;
    while (!(write && address == ADDR_W'(2)) && n < 500) begin @(negedge clk); n++; end
    chk("t4_found", write, 1);
    reset = 1'b0;
    #1;
    chk("t4_write", write, 0);
    chk("t4_read", read, 0);
    chk("t4_busy", busy, 0);
    chk("t4_addr", address, 0);
    @(negedge clk);
    reset = 1'b1;
    w0 = writes; r0 = reads;
    pulse_start();
    wait_done("t4_done");
    chk("t4_pass", pass, 1);
    chk("t4_err", error_count, 0);
    chk("t4_writes", writes - w0, 16);
    chk("t4_reads", reads - r0, 16);

    chk("handshake_viol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
